div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//   Request/response front-end for the 32/16 restoring divider core (div_restoring).
//   Accepts operands on a valid/ready handshake, converts signed operands to magnitudes,
//   pulses core start, waits for core ready, sign-corrects q/r, holds the result on a
//   valid/ready output. Divide-by-zero is bypassed without using the core; a watchdog
//   catches a core that never completes.
// PARAMETERS
//   TIMEOUT  40            max WAIT cycles before error; must be > 33
//   ZERO_Q   32'hFFFF_FFFF quotient returned on divide-by-zero
// PORTS
//   clk         in   1   clock, rising edge
//   clrn        in   1   reset, asynchronous, active-low
//   in_valid    in   1   request valid
//   in_ready    out  1   request accepted when in_valid & in_ready
//   in_a        in   32  dividend
//   in_b        in   16  divisor
//   in_signed   in   1   1 = two's-complement operands (needs DIV_SIGNED_EN)
//   out_valid   out  1   result valid
//   out_ready   in   1   result consumed when out_valid & out_ready
//   out_q       out  32  quotient
//   out_r       out  16  remainder
//   out_dz      out  1   divide-by-zero flag
//   out_ovf     out  1   signed overflow flag (-2^31 / -1)
//   out_err     out  1   core timeout flag
//   core_a      out  32  to core a (registered)
//   core_b      out  16  to core b (registered)
//   core_start  out  1   to core start, one-cycle pulse
//   core_ready  in   1   from core ready
//   core_q      in   32  from core q
//   core_r      in   16  from core r
// BEHAVIOUR
//   - Reset (clrn=0, async): state IDLE; all registered outputs, flags, core_a/core_b 0;
//     core_start 0; out_valid 0. Reset mid-operation aborts; core shares clrn.
//   - in_ready = (state==IDLE), combinational. No accept while OUT is pending.
//   - IDLE: on accept, latch operands and sign flags sq = sa^sb, sr = sa (sa=in_a[31]&sgn,
//     sb=in_b[15]&sgn). If in_b==0 go OUT with out_q=ZERO_Q, out_r=in_a[15:0], out_dz=1.
//     Else load core_a=|a| (32b), core_b=|b| (16b), go START.
//   - START: core_start=1 for exactly one cycle; go WAIT, clear watchdog counter.
//   - WAIT: core_start=0; core_ready sampled from the first WAIT cycle (core cleared it on
//     the START edge). On core_ready=1 go FIX. Counter++ each WAIT cycle; at TIMEOUT go
//     OUT with out_q=0, out_r=0, out_err=1.
//   - FIX: out_q = sq ? -core_q : core_q (32b wrap); out_r = sr ? -core_r : core_r (16b).
//     out_ovf=1 if signed and in_a==32'h8000_0000 and in_b==16'hFFFF (out_q=32'h8000_0000).
//     Go OUT.
//   - OUT: out_valid=1; out_q/r and flags stable until out_ready=1, then IDLE,
//     out_valid=0. Flags persist until the next accept, which clears them.
//   - Latency accept->out_valid: normal 35 cycles (START 1 + core 32 + WAIT detect 1 +
//     FIX 1); divide-by-zero 1 cycle; timeout TIMEOUT+2.
//   - Truncation toward zero: remainder carries the dividend's sign; |r| < |b|.
//   - |b| = 32768 for b=16'h8000 fits unsigned 16b; |a| = 2^31 fits unsigned 32b.
// CONFIGURATION
//   DIV_SIGNED_EN defined: in_signed honoured as above.
//   Not defined: in_signed ignored; sa=sb=0; FIX passes core_q/core_r through;
//     out_ovf tied 0; negation logic not built.
// TESTING
//   - Unsigned 100/7: accept -> out_valid after 35 cycles, q=14, r=2, flags 0.
//   - Signed -100/7 (DIV_SIGNED_EN): q=32'hFFFF_FFF2 (-14), r=16'hFFFE (-2).
//   - Signed 100/-7 -> q=-14, r=2. Signed 32'h8000_0000/16'hFFFF -> q=32'h8000_0000, ovf=1.
//   - in_b=0, in_a=32'h1234_5678: out_valid next cycle, q=ZERO_Q, r=16'h5678, dz=1;
//     core_start never pulses.
//   - Hold out_ready=0 for 10 cycles: outputs stable, in_ready=0; then out_ready=1 ->
//     IDLE, in_ready=1.
//   - Stub core that never asserts ready: out_err=1 after TIMEOUT+2; assert clrn=0 in WAIT ->
//     IDLE, out_valid=0.

Source files
------------

// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between a requester and div_seq_ctrl.
// The master side issues operands and consumes results; the slave side is the controller.
interface div_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [15:0] in_b;
   logic        in_signed;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_q;
   logic [15:0] out_r;
   logic        out_dz;
   logic        out_ovf;
   logic        out_err;

   modport master (
      output in_valid, in_a, in_b, in_signed, out_ready,
      input  in_ready, out_valid, out_q, out_r, out_dz, out_ovf, out_err
   );

   modport slave (
      input  in_valid, in_a, in_b, in_signed, out_ready,
      output in_ready, out_valid, out_q, out_r, out_dz, out_ovf, out_err
   );
endinterface

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: valid/ready front-end sequencing the 32/16 restoring divider core.
// Define DIV_SIGNED_EN to honour in_signed (magnitude conversion and sign fix-up).
module div_seq_ctrl #(
   parameter int unsigned TIMEOUT = 40,
   parameter logic [31:0] ZERO_Q  = 32'hFFFF_FFFF
) (
   input  logic          clk,
   input  logic          clrn,
   div_seq_ctrl_if.slave bus,
   output logic [31:0]   core_a,
   output logic [15:0]   core_b,
   output logic          core_start,
   input  logic          core_ready,
   input  logic [31:0]   core_q,
   input  logic [15:0]   core_r
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, START, WAIT, FIX, OUT} state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] wd_cnt_reg;
   logic [31:0]      q_reg;
   logic [15:0]      r_reg;
   logic             valid_reg;
   logic             dz_reg;
   logic             err_reg;

   logic [31:0]      mag_a;
   logic [15:0]      mag_b;
   logic [31:0]      fix_q;
   logic [15:0]      fix_r;
   logic             accept;

   assign accept        = (state_reg == IDLE) && bus.in_valid;
   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = valid_reg;
   assign bus.out_q     = q_reg;
   assign bus.out_r     = r_reg;
   assign bus.out_dz    = dz_reg;
   assign bus.out_err   = err_reg;

`ifdef DIV_SIGNED_EN
   logic sa;
   logic sb;
   logic sq_reg;
   logic sr_reg;
   logic ovf_pend_reg;
   logic ovf_reg;

   assign sa    = bus.in_a[31] & bus.in_signed;
   assign sb    = bus.in_b[15] & bus.in_signed;
   // Negating -2^31 and -32768 wraps to the same pattern, which is the correct unsigned magnitude.
   assign mag_a = sa ? (32'd0 - bus.in_a) : bus.in_a;
   assign mag_b = sb ? (16'd0 - bus.in_b) : bus.in_b;
   assign fix_q = sq_reg ? (32'd0 - core_q) : core_q;
   assign fix_r = sr_reg ? (16'd0 - core_r) : core_r;
   assign bus.out_ovf = ovf_reg;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sq_reg       <= 1'b0;
         sr_reg       <= 1'b0;
         ovf_pend_reg <= 1'b0;
         ovf_reg      <= 1'b0;
      end else if (accept) begin
         sq_reg       <= sa ^ sb;
         sr_reg       <= sa;
         ovf_pend_reg <= bus.in_signed && (bus.in_a == 32'h8000_0000) && (bus.in_b == 16'hFFFF);
         ovf_reg      <= 1'b0;
      end else if (state_reg == FIX) begin
         ovf_reg      <= ovf_pend_reg;
      end
   end
`else
   logic unused_signed;

   assign unused_signed = bus.in_signed;
   assign mag_a         = bus.in_a;
   assign mag_b         = bus.in_b;
   assign fix_q         = core_q;
   assign fix_r         = core_r;
   assign bus.out_ovf   = 1'b0;
`endif

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_reg  <= IDLE;
         wd_cnt_reg <= '0;
         q_reg      <= 32'd0;
         r_reg      <= 16'd0;
         valid_reg  <= 1'b0;
         dz_reg     <= 1'b0;
         err_reg    <= 1'b0;
         core_a     <= 32'd0;
         core_b     <= 16'd0;
         core_start <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.in_valid) begin
                  dz_reg  <= 1'b0;
                  err_reg <= 1'b0;
                  if (bus.in_b == 16'd0) begin
                     // Divide-by-zero never touches the core.
                     q_reg     <= ZERO_Q;
                     r_reg     <= bus.in_a[15:0];
                     dz_reg    <= 1'b1;
                     valid_reg <= 1'b1;
                     state_reg <= OUT;
                  end else begin
                     core_a     <= mag_a;
                     core_b     <= mag_b;
                     core_start <= 1'b1;
                     state_reg  <= START;
                  end
               end
            end

            START: begin
               core_start <= 1'b0;
               wd_cnt_reg <= '0;
               state_reg  <= WAIT;
            end

            WAIT: begin
               if (core_ready) begin
                  state_reg <= FIX;
               end else if (wd_cnt_reg == CNT_LAST) begin
                  q_reg     <= 32'd0;
                  r_reg     <= 16'd0;
                  err_reg   <= 1'b1;
                  valid_reg <= 1'b1;
                  state_reg <= OUT;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
               end
            end

            FIX: begin
               q_reg     <= fix_q;
               r_reg     <= fix_r;
               valid_reg <= 1'b1;
               state_reg <= OUT;
            end

            OUT: begin
               if (bus.out_ready) begin
                  valid_reg <= 1'b0;
                  state_reg <= IDLE;
               end
            end

            default: begin
               core_start <= 1'b0;
               valid_reg  <= 1'b0;
               state_reg  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a 32-cycle behavioural divider core stub.
// Signed vectors run only when DIV_SIGNED_EN is defined.
module tb_div_seq_ctrl;
   localparam int TIMEOUT = 40;

   logic        clk  = 1'b0;
   logic        clrn = 1'b0;
   logic [31:0] core_a;
   logic [15:0] core_b;
   logic        core_start;
   logic        core_ready;
   logic [31:0] core_q;
   logic [15:0] core_r;

   int checks = 0;
   int errors = 0;
   int start_pulses = 0;

   div_seq_ctrl_if bus ();

   div_seq_ctrl #(.TIMEOUT(TIMEOUT), .ZERO_Q(32'hFFFF_FFFF)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .bus        (bus),
      .core_a     (core_a),
      .core_b     (core_b),
      .core_start (core_start),
      .core_ready (core_ready),
      .core_q     (core_q),
      .core_r     (core_r)
   );

   always #5 clk = ~clk;

   // Core stub: ready idles high, drops on the start edge, returns 31 edges later.
   logic       core_dead = 1'b0;
   logic       core_busy;
   logic [5:0] core_cnt;

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         core_ready <= 1'b1;
         core_busy  <= 1'b0;
         core_cnt   <= 6'd0;
         core_q     <= 32'd0;
         core_r     <= 16'd0;
      end else if (core_start) begin
         core_ready <= 1'b0;
         core_busy  <= 1'b1;
         core_cnt   <= 6'd31;
         core_q     <= core_a / {16'h0, core_b};
         core_r     <= 16'(core_a % {16'h0, core_b});
      end else if (core_busy) begin
         core_cnt <= core_cnt - 6'd1;
         if (core_cnt == 6'd1 && !core_dead) begin
            core_ready <= 1'b1;
            core_busy  <= 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (core_start) start_pulses <= start_pulses + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "bench timed out");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [15:0] b, input logic sgn);
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_signed = sgn;
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 1;
      while (!bus.out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic consume(input string tag);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [15:0] b,
                      input logic sgn, input logic [31:0] ca, input logic [15:0] cb,
                      input int lat, input logic [31:0] eq, input logic [15:0] er,
                      input logic edz, input logic eovf, input logic eerr, input int epulse);
      int cyc;
      int p0;
      p0 = start_pulses;
      issue(a, b, sgn);
      if (b != 16'd0) begin
         chk({tag, "_core_a"}, core_a, ca);
         chk({tag, "_core_b"}, 32'(core_b), 32'(cb));
         chk({tag, "_core_start"}, 32'(core_start), 32'd1);
      end
      wait_out(cyc);
      chk({tag, "_latency"}, 32'(cyc), 32'(lat));
      chk({tag, "_q"}, bus.out_q, eq);
      chk({tag, "_r"}, 32'(bus.out_r), 32'(er));
      chk({tag, "_flags"}, {29'd0, bus.out_dz, bus.out_ovf, bus.out_err}, {29'd0, edz, eovf, eerr});
      chk({tag, "_pulses"}, 32'(start_pulses - p0), 32'(epulse));
      $display("txn %s: a=%h b=%h sgn=%0d -> q=%h r=%h dz=%0d ovf=%0d err=%0d lat=%0d",
               tag, a, b, sgn, bus.out_q, bus.out_r, bus.out_dz, bus.out_ovf, bus.out_err, cyc);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = 32'd0;
      bus.in_b      = 16'd0;
      bus.in_signed = 1'b0;
      bus.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_core_start", 32'(core_start), 32'd0);
      chk("rst_core_a", core_a, 32'd0);
      chk("rst_core_b", 32'(core_b), 32'd0);
      chk("rst_out_q", bus.out_q, 32'd0);
      chk("rst_flags", {29'd0, bus.out_dz, bus.out_ovf, bus.out_err}, 32'd0);
      clrn = 1'b1;
      @(negedge clk);

      // 100/7 then hold the result for 10 cycles while a second request waits.
      run("u100_7", 32'd100, 16'd7, 1'b0, 32'd100, 16'd7, 35, 32'd14, 16'd2, 1'b0, 1'b0, 1'b0, 1);
      bus.in_valid = 1'b1;
      bus.in_a     = 32'd5;
      bus.in_b     = 16'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_q", bus.out_q, 32'd14);
         chk("hold_r", 32'(bus.out_r), 32'd2);
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      consume("hold");

      run("u_max", 32'hFFFF_FFFF, 16'hFFFF, 1'b0, 32'hFFFF_FFFF, 16'hFFFF, 35,
          32'h0001_0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1);
      consume("u_max");
      run("u1000_3", 32'd1000, 16'd3, 1'b0, 32'd1000, 16'd3, 35, 32'd333, 16'd1, 1'b0, 1'b0, 1'b0, 1);
      consume("u1000_3");

      run("dz", 32'h1234_5678, 16'h0000, 1'b0, 32'd0, 16'd0, 1,
          32'hFFFF_FFFF, 16'h5678, 1'b1, 1'b0, 1'b0, 0);
      consume("dz");
      run("dz_clear", 32'd100, 16'd7, 1'b0, 32'd100, 16'd7, 35, 32'd14, 16'd2, 1'b0, 1'b0, 1'b0, 1);
      consume("dz_clear");

`ifdef DIV_SIGNED_EN
      run("s_m100_7", 32'hFFFF_FF9C, 16'd7, 1'b1, 32'd100, 16'd7, 35,
          32'hFFFF_FFF2, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1);
      consume("s_m100_7");
      run("s_100_m7", 32'd100, 16'hFFF9, 1'b1, 32'd100, 16'd7, 35,
          32'hFFFF_FFF2, 16'h0002, 1'b0, 1'b0, 1'b0, 1);
      consume("s_100_m7");
      run("s_ovf", 32'h8000_0000, 16'hFFFF, 1'b1, 32'h8000_0000, 16'd1, 35,
          32'h8000_0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1);
      consume("s_ovf");
      run("s_bmin", 32'hFFFE_7960, 16'h8000, 1'b1, 32'h0001_86A0, 16'h8000, 35,
          32'd3, 16'hF960, 1'b0, 1'b0, 1'b0, 1);
      consume("s_bmin");
`else
      run("sgn_ignored", 32'hFFFF_FF9C, 16'd7, 1'b1, 32'hFFFF_FF9C, 16'd7, 35,
          32'h2492_4916, 16'h0002, 1'b0, 1'b0, 1'b0, 1);
      consume("sgn_ignored");
      run("sgn_ovf_off", 32'h8000_0000, 16'hFFFF, 1'b1, 32'h8000_0000, 16'hFFFF, 35,
          32'h0000_8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1);
      consume("sgn_ovf_off");
`endif

      // Core that never answers: watchdog result, then next accept clears err.
      core_dead = 1'b1;
      run("timeout", 32'd1000, 16'd3, 1'b0, 32'd1000, 16'd3, TIMEOUT + 2,
          32'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1);
      consume("timeout");
      core_dead = 1'b0;
      run("err_clear", 32'd1000, 16'd3, 1'b0, 32'd1000, 16'd3, 35, 32'd333, 16'd1, 1'b0, 1'b0, 1'b0, 1);
      consume("err_clear");

      // Asynchronous reset while waiting on a dead core.
      core_dead = 1'b1;
      issue(32'd77, 16'd5, 1'b0);
      repeat (5) @(negedge clk);
      chk("wait_core_start", 32'(core_start), 32'd0);
      chk("wait_in_ready", 32'(bus.in_ready), 32'd0);
      #2 clrn = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("arst_core_a", core_a, 32'd0);
      chk("arst_core_b", 32'(core_b), 32'd0);
      $display("txn arst: reset asserted in WAIT -> out_valid=%0d in_ready=%0d",
               bus.out_valid, bus.in_ready);
      @(negedge clk);
      clrn      = 1'b1;
      core_dead = 1'b0;
      @(negedge clk);
      run("post_rst", 32'd100, 16'd7, 1'b0, 32'd100, 16'd7, 35, 32'd14, 16'd2, 1'b0, 1'b0, 1'b0, 1);
      consume("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
